// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds FSM states, the {pc,word} buffer entry and defaults.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  function automatic logic [31:0] align_word(
    input logic [31:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Small instruction buffer of {pc,word} entries with flush.
// Ports: clk, reset (async high), push/push_data, pop,
//   flush (clears all entries), head (oldest entry), count.
module instruction_fetch_unit_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues sync imem reads,
// buffers responses and hands {word,pc} to decode.
// Ports: clk, reset (async high); imem_addr/imem_req out,
//   imem_rdata in; redirect_valid/redirect_pc in;
//   inst_valid/inst_data/inst_pc out, inst_ready in.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          pop;
  logic          active;
  logic          issue;
  fetch_entry_t  push_data;
  fetch_entry_t  head;

  assign pop    = inst_valid && inst_ready;
  assign active = (state == FETCH) || (state == FLUSH);

  // Slots claimed after this cycle's pop; an issue is
  // only allowed when its response is sure to fit.
  assign used  = {1'b0, count}
               + (CW+1)'(inflight)
               - (CW+1)'(pop);
  assign issue = active
              && (used < (CW+1)'(FIFO_DEPTH));

  assign imem_req  = issue;
  assign imem_addr = pc;

  assign push_data.pc   = resp_pc;
  assign push_data.word = imem_rdata;

  assign inst_valid = (count != '0);
  assign inst_pc    = head.pc;
  assign inst_data  = head.word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      resp_pc  <= '0;
      inflight <= 1'b0;
    end else begin
      // A redirect kills the request issued this cycle,
      // so its response is never pushed.
      inflight <= issue && !redirect_valid;
      if (issue) begin
        resp_pc <= pc;
      end
      unique case (state)
        BOOT:  state <= FETCH;
        FETCH,
        FLUSH: state <= redirect_valid ? FLUSH : FETCH;
        default: state <= BOOT;
      endcase
      if (redirect_valid) begin
        pc <= align_word(redirect_pc);
      end else if (issue) begin
        pc <= pc + 32'd4;
      end
    end
  end

  instruction_fetch_unit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit.
// Memory word at address a is a>>2.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_fetch_unit #(
    .RESET_PC   (DEF_RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(
    input logic [31:0] a
  );
    return a >> 2;
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= word_at(imem_addr);
  end

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rv, input logic [31:0] rpc,
    input logic rdy, input logic ereq,
    input logic [31:0] eaddr, input logic evalid,
    input logic [31:0] epc
  );
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ereq = ereq; v.eaddr = eaddr;
    v.evalid = evalid; v.epc = epc;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic rv, input logic [31:0] rpc,
    input logic rdy
  );
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
  endtask

  task automatic to_next;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 (BOOT).
  task automatic do_reset;
    drive(1'b0, '0, 1'b0);
    reset = 1'b1;
    to_next;
    to_next;
    reset = 1'b0;
  endtask

  logic        rv;
  logic        rdy;
  logic [31:0] rpc;
  logic [31:0] exp_pc;
  logic [31:0] prev_pc;
  logic [31:0] prev_data;
  logic        hold;
  int          since;
  int          pops;
  int          k;

  initial begin
    // cycle-by-cycle vectors from reset release
    tbl.push_back(mk(0, 0, 1, 0, 32'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h04, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h08, 1, 32'h00));
    tbl.push_back(mk(0, 0, 1, 1, 32'h0C, 1, 32'h04));
    tbl.push_back(mk(0, 0, 1, 1, 32'h10, 1, 32'h08));
    tbl.push_back(mk(0, 0, 1, 1, 32'h14, 1, 32'h0C));
    tbl.push_back(mk(0, 0, 1, 1, 32'h18, 1, 32'h10));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0, 0, 0, 32'h1C, 1, 32'h14));
    tbl.push_back(mk(0, 0, 1, 1, 32'h1C, 1, 32'h14));
    tbl.push_back(mk(0, 0, 1, 1, 32'h20, 1, 32'h18));
    tbl.push_back(mk(0, 0, 1, 1, 32'h24, 1, 32'h1C));
    tbl.push_back(mk(0, 0, 1, 1, 32'h28, 1, 32'h20));
    tbl.push_back(mk(1, 32'h103, 1, 1, 32'h2C, 1, 32'h24));
    tbl.push_back(mk(0, 0, 1, 1, 32'h100, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h104, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h108, 1, 32'h100));
    tbl.push_back(mk(0, 0, 1, 1, 32'h10C, 1, 32'h104));
    tbl.push_back(mk(1, 32'hFFFF_FFF8, 1, 1,
                     32'h110, 1, 32'h108));
    tbl.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h0,
                     1, 32'hFFFF_FFF8));
    tbl.push_back(mk(0, 0, 1, 1, 32'h4,
                     1, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 1, 1, 32'h8, 1, 32'h0));

    // reset values while held in reset
    #2;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, DEF_RESET_PC);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);

    do_reset;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("t%0d_req", i),
          32'(imem_req), 32'(tbl[i].ereq));
      chk($sformatf("t%0d_addr", i),
          imem_addr, tbl[i].eaddr);
      chk($sformatf("t%0d_valid", i),
          32'(inst_valid), 32'(tbl[i].evalid));
      if (tbl[i].evalid) begin
        chk($sformatf("t%0d_pc", i),
            inst_pc, tbl[i].epc);
        chk($sformatf("t%0d_data", i),
            inst_data, word_at(tbl[i].epc));
      end
      to_next;
    end

    // full buffer: redirect with simultaneous pop
    do_reset;
    repeat (5) to_next;
    drive(1'b1, 32'h200, 1'b1);
    @(negedge clk);
    chk("full_valid", 32'(inst_valid), 1);
    chk("full_pop_pc", inst_pc, 32'h0);
    to_next;
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("full_bub1", 32'(inst_valid), 0);
    to_next;
    @(negedge clk);
    chk("full_bub2", 32'(inst_valid), 0);
    to_next;
    @(negedge clk);
    chk("full_tgt_pc", inst_pc, 32'h200);
    chk("full_tgt_data", inst_data, 32'h80);
    to_next;
    @(negedge clk);
    chk("full_next_pc", inst_pc, 32'h204);
    to_next;

    // redirect during BOOT, then back-to-back redirects
    do_reset;
    drive(1'b1, 32'h41, 1'b1);
    @(negedge clk);
    chk("boot_req", 32'(imem_req), 0);
    to_next;
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("boot_first_addr", imem_addr, 32'h40);
    to_next;
    to_next;
    @(negedge clk);
    chk("boot_first_pc", inst_pc, 32'h40);
    to_next;
    drive(1'b1, 32'h300, 1'b1);
    to_next;
    drive(1'b1, 32'h400, 1'b1);
    @(negedge clk);
    chk("b2b_addr1", imem_addr, 32'h300);
    chk("b2b_v1", 32'(inst_valid), 0);
    to_next;
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("b2b_addr2", imem_addr, 32'h400);
    chk("b2b_v2", 32'(inst_valid), 0);
    to_next;
    @(negedge clk);
    chk("b2b_v3", 32'(inst_valid), 0);
    to_next;
    @(negedge clk);
    chk("b2b_pc", inst_pc, 32'h400);
    chk("b2b_data", inst_data, 32'h100);
    to_next;

    // reset mid-stream with a fetch in flight
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(inst_valid), 0);
    chk("mid_rst_req", 32'(imem_req), 0);
    to_next;
    reset = 1'b0;
    k = 0;
    while (k < 8) begin
      @(negedge clk);
      if (inst_valid) break;
      k++;
      to_next;
    end
    chk("mid_rst_latency", k, 3);
    chk("mid_rst_pc", inst_pc, DEF_RESET_PC);
    chk("mid_rst_data", inst_data, 32'h0);
    to_next;

    // randomized run against a stream-level model
    do_reset;
    exp_pc    = DEF_RESET_PC;
    since     = 0;
    hold      = 1'b0;
    pops      = 0;
    prev_pc   = '0;
    prev_data = '0;
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 99) < 4);
      rdy = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 3) == 0)
        rpc = 32'hFFFF_FFF0
            | 32'($urandom_range(0, 15));
      else
        rpc = $urandom;
      drive(rv, rpc, rdy);
      @(negedge clk);
      if (since == 1 || since == 2)
        chk("rnd_bubble", 32'(inst_valid), 0);
      if (since == 3)
        chk("rnd_latency", 32'(inst_valid), 1);
      if (hold) begin
        chk("rnd_hold_v", 32'(inst_valid), 1);
        chk("rnd_hold_pc", inst_pc, prev_pc);
        chk("rnd_hold_d", inst_data, prev_data);
      end
      if (inst_valid && rdy) begin
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_data", inst_data, word_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (rv) exp_pc = {rpc[31:2], 2'b00};
      hold      = inst_valid && !rdy && !rv;
      prev_pc   = inst_pc;
      prev_data = inst_data;
      since     = rv ? 1 : since + 1;
      to_next;
    end
    chk("rnd_progress", 32'(pops > 500), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
